// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the decode side, the ALU execute stage and writeback.
// The stage takes the slave modport and its driver takes the master modport.
interface alu_exec_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             op_err;

    modport master (
        output in_valid, a, b, operation, out_ready,
        input  in_ready, out_valid, result, zero, op_err
    );

    modport slave (
        input  in_valid, a, b, operation, out_ready,
        output in_ready, out_valid, result, zero, op_err
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready on both sides.
// Define ALU_EXEC_MUL_EN to add the iterative shift-add multiplier for code 1000.
module alu_exec_stage #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_stage_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FULL = 2'b01;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'b10;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam int         CW      = $clog2(WIDTH) + 1;
`endif

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             op_err_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             is_mul_s;
    logic [WIDTH:0]   alu_out_s;
`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic             mul_done_s;
`endif

    // Single-cycle result; the top bit flags an unsupported code.
    function automatic logic [WIDTH:0] alu_calc(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        r = {1'b0, {WIDTH{1'b0}}};
        case (op)
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_ADD:  r = {1'b0, x + y};
            OP_SUB:  r = {1'b0, x - y};
            OP_SLT:  r = {1'b0, {(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_NOR:  r = {1'b0, ~(x | y)};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    // Handshake decode; in_ready follows out_ready combinationally (no skid buffer).
    always_comb begin
`ifdef ALU_EXEC_MUL_EN
        in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_FULL) && bus.out_ready);
        is_mul_s   = (bus.operation == OP_MUL);
        acc_nx_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        mul_done_s = (state_r == ST_MUL) && (count_r == CW'(WIDTH - 1));
`else
        in_ready_s = (state_r == ST_IDLE) || bus.out_ready;
        is_mul_s   = 1'b0;
`endif
        accept_s  = bus.in_valid && in_ready_s;
        alu_out_s = alu_calc(bus.operation, bus.a, bus.b);
    end

    // Next-state selection for IDLE / FULL / MUL.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_FULL: begin
                if (accept_s) begin
`ifdef ALU_EXEC_MUL_EN
                    state_nx_s = is_mul_s ? ST_MUL : ST_FULL;
`else
                    state_nx_s = ST_FULL;
`endif
                end else if ((state_r == ST_FULL) && !bus.out_ready) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
`endif
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, valid flag and the result/zero/op_err register set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            op_err_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s == ST_FULL);
            if (accept_s && !is_mul_s) begin
                result_r <= alu_out_s[WIDTH-1:0];
                zero_r   <= (alu_out_s[WIDTH-1:0] == {WIDTH{1'b0}});
                op_err_r <= alu_out_s[WIDTH];
`ifdef ALU_EXEC_MUL_EN
            end else if (mul_done_s) begin
                result_r <= acc_nx_s;
                zero_r   <= (acc_nx_s == {WIDTH{1'b0}});
                op_err_r <= 1'b0;
`endif
            end else begin
                result_r <= result_r;
                zero_r   <= zero_r;
                op_err_r <= op_err_r;
            end
        end
    end

`ifdef ALU_EXEC_MUL_EN
    // Shift-add multiplier: one multiplier bit consumed per cycle, low WIDTH bits kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (accept_s && is_mul_s) begin
            mcand_r  <= bus.a;
            mplier_r <= bus.b;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (state_r == ST_MUL) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_nx_s;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            count_r  <= count_r;
        end
    end
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.op_err    = op_err_r;
endmodule
